// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned MUL_ITERS = 16;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_e;

    // Radix-4 Booth partial-product selection.
    typedef enum logic [2:0] {
        ZERO,
        PLUS1,
        PLUS2,
        MINUS1,
        MINUS2
    } booth_sel_e;

endpackage

// File: rtl/multdiv_booth_recoder.sv
// Radix-4 modified Booth recoder: maps {b[i+1], b[i], b[i-1]} to a multiple of M.
module booth_recoder
    import multdiv_pkg::*;
(
    input  logic [2:0] bits,
    output booth_sel_e sel_c
);

    // Recode the overlapping bit triple into 0, +/-M or +/-2M.
    always_comb begin
        sel_c = ZERO;
        case (bits)
            3'b000:  sel_c = ZERO;
            3'b001:  sel_c = PLUS1;
            3'b010:  sel_c = PLUS1;
            3'b011:  sel_c = PLUS2;
            3'b100:  sel_c = MINUS2;
            3'b101:  sel_c = MINUS1;
            3'b110:  sel_c = MINUS1;
            3'b111:  sel_c = ZERO;
            default: sel_c = ZERO;
        endcase
    end

endmodule

// File: rtl/multdiv.sv
// Iterative signed multiply (radix-4 Booth) / divide (non-restoring) unit.
module multdiv
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned ACC_W  = WIDTH + 2;
    localparam int unsigned PROD_W = ACC_W + WIDTH + 1;

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] count;

    logic             start_mul;
    logic             start_div;
    logic             start;
    logic             div_by_zero_c;
    logic             div_ovf_c;

    // Multiply datapath: {acc, mplr, qm1} forms the Booth product register.
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] mplr;
    logic             qm1;
    logic [WIDTH-1:0] mcand;

    // Divide datapath: partial remainder, dividend/quotient shift register, divisor magnitude.
    logic [ACC_W-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             div_zero;
    logic             div_ovf;
    logic             op_div;

    booth_sel_e              sel_c;
    logic [ACC_W-1:0]        m_ext_c;
    logic [ACC_W-1:0]        addend_c;
    logic [ACC_W-1:0]        acc_sum_c;
    logic signed [PROD_W-1:0] prod_shift_c;
    logic [ACC_W-1:0]        d_ext_c;
    logic [ACC_W-1:0]        rem_shift_c;
    logic [ACC_W-1:0]        rem_next_c;
    logic [WIDTH-1:0]        abs_a_c;
    logic [WIDTH-1:0]        abs_b_c;
    logic [WIDTH:0]          prod_hi_c;

    // MULT has priority when both start pulses arrive together.
    assign start_mul     = ctrl_MULT;
    assign start_div     = ctrl_DIV & ~ctrl_MULT;
    assign start         = ctrl_MULT | ctrl_DIV;
    assign div_by_zero_c = (data_operandB == '0);
    assign div_ovf_c     = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) & (&data_operandB);

    assign abs_a_c = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    assign abs_b_c = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

    booth_recoder u_booth_recoder (
        .bits  ({mplr[1:0], qm1}),
        .sel_c (sel_c)
    );

    assign m_ext_c = {{2{mcand[WIDTH-1]}}, mcand};

    // Select the Booth partial product for this iteration.
    always_comb begin
        addend_c = '0;
        case (sel_c)
            ZERO:    addend_c = '0;
            PLUS1:   addend_c = m_ext_c;
            PLUS2:   addend_c = m_ext_c << 1;
            MINUS1:  addend_c = ~m_ext_c + ACC_W'(1);
            MINUS2:  addend_c = ~(m_ext_c << 1) + ACC_W'(1);
            default: addend_c = '0;
        endcase
    end

    assign acc_sum_c    = acc + addend_c;
    assign prod_shift_c = $signed({acc_sum_c, mplr, qm1}) >>> 2;
    assign prod_hi_c    = {acc[WIDTH-1:0], mplr[WIDTH-1]};

    // Non-restoring step: subtract on a non-negative remainder, add back otherwise.
    assign d_ext_c     = {2'b00, dvsr};
    assign rem_shift_c = {rem[ACC_W-2:0], quo[WIDTH-1]};
    assign rem_next_c  = rem[ACC_W-1] ? (rem_shift_c + d_ext_c) : (rem_shift_c - d_ext_c);

    // Next-state logic; a start pulse restarts from any state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            MUL:     if (count == CNT_W'(MUL_ITERS - 1)) state_next = FIX;
            DIV:     if (count == CNT_W'(DIV_ITERS - 1)) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (start_mul) begin
            state_next = MUL;
        end else if (start_div) begin
            state_next = div_by_zero_c ? FIX : DIV;
        end
    end

    // State register, iteration counter and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            busy           <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            state          <= state_next;
            busy           <= (state_next != IDLE);
            data_resultRDY <= (state_next == DONE);
            if (start) begin
                count <= '0;
            end else if ((state == MUL) || (state == DIV)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Operand capture, iteration datapath and final result correction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc            <= '0;
            mplr           <= '0;
            qm1            <= 1'b0;
            mcand          <= '0;
            rem            <= '0;
            quo            <= '0;
            dvsr           <= '0;
            neg_q          <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            op_div         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start_mul) begin
            acc    <= '0;
            mplr   <= data_operandB;
            qm1    <= 1'b0;
            mcand  <= data_operandA;
            op_div <= 1'b0;
        end else if (start_div) begin
            rem      <= '0;
            quo      <= abs_a_c;
            dvsr     <= abs_b_c;
            neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= div_by_zero_c;
            div_ovf  <= div_ovf_c;
            op_div   <= 1'b1;
        end else begin
            case (state)
                MUL: begin
                    acc  <= ACC_W'(prod_shift_c[PROD_W-1 -: ACC_W]);
                    mplr <= prod_shift_c[WIDTH:1];
                    qm1  <= prod_shift_c[0];
                end
                DIV: begin
                    rem <= rem_next_c;
                    quo <= {quo[WIDTH-2:0], ~rem_next_c[ACC_W-1]};
                end
                FIX: begin
                    if (op_div) begin
                        if (rem[ACC_W-1]) begin
                            rem <= rem + d_ext_c;
                        end
                        if (div_zero) begin
                            data_result <= '0;
                        end else begin
                            data_result <= neg_q ? (~quo + WIDTH'(1)) : quo;
                        end
                        data_exception <= div_zero | div_ovf;
                    end else begin
                        data_result    <= mplr;
                        data_exception <= ~((&prod_hi_c) | ~(|prod_hi_c));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
